// File: rtl/sorted_array_loader.sv
// Online insertion-sort loader: keeps up to DEPTH keys sorted ascending and
// exposes them to the binary-search datapath through a combinational read port.
module sorted_array_loader #(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int DW    = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          in_ready,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data,
    output logic [AW:0]   count,
    output logic          full,
    output logic          busy,
    output logic          search_ok
);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t        state_q;
    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] key_q;
    logic [AW-1:0] pos_q;
    logic [AW:0]   count_q;

    logic [DW-1:0] prev_data;
    logic          do_shift;
    logic          accept;
    logic [DW-1:0] wr_data;

    // Guard position 0 so the entry below the array is never consulted.
    assign prev_data = (pos_q != '0) ? mem_q[pos_q - 1'b1] : '0;
    assign do_shift  = (pos_q != '0) && (prev_data > key_q);
    assign wr_data   = do_shift ? prev_data : key_q;

    assign full      = (count_q == (AW+1)'(DEPTH));
    assign busy      = (state_q == SHIFT);
    assign search_ok = full && !busy;
    assign in_ready  = (state_q == IDLE) && !full && !rst && !clr;
    assign accept    = in_valid && in_ready;
    assign count     = count_q;
    assign rd_data   = mem_q[rd_addr];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            count_q <= '0;
            key_q   <= '0;
            pos_q   <= '0;
        end else if (clr) begin
            state_q <= IDLE;
            count_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        key_q   <= in_data;
                        pos_q   <= count_q[AW-1:0];
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (do_shift) begin
                        pos_q <= pos_q - 1'b1;
                    end else begin
                        count_q <= count_q + 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Each slot is written only when the insertion cursor sits on it.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_mem
            always_ff @(posedge clk) begin
                if (rst) begin
                    mem_q[gi] <= '0;
                end else if (!clr && state_q == SHIFT && pos_q == AW'(gi)) begin
                    mem_q[gi] <= wr_data;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_sorted_array_loader.sv
// Scoreboard bench for sorted_array_loader: stimulus queues expectations,
// a negedge monitor pops and compares them against the DUT.
module tb_sorted_array_loader;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clr = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_ready;
    logic [3:0] rd_addr = 4'h0;
    logic [7:0] rd_data;
    logic [4:0] count;
    logic       full;
    logic       busy;
    logic       search_ok;

    always #5 clk = ~clk;

    sorted_array_loader #(.DEPTH(16), .AW(4), .DW(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .count    (count),
        .full     (full),
        .busy     (busy),
        .search_ok(search_ok)
    );

    typedef struct {int kind; int exp;} chk_t;
    typedef struct {int busy_len; int cnt;} ins_t;

    chk_t sb_q[$];
    ins_t ins_q[$];
    int   ref_q[$];
    int   n_chk = 0;
    int   n_pass = 0;
    int   cyc = 0;
    int   last_acc = 0;
    int   lat_meas = 0;
    int   run_len = 0;
    logic chk_stb = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(string name, int act, int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    endfunction

    // Monitor: status/read checks on strobe, insertion checks on busy falling.
    always @(negedge clk) begin
        if (chk_stb) begin
            while (sb_q.size() > 0) begin
                chk_t e;
                e = sb_q.pop_front();
                case (e.kind)
                    0: check($sformatf("rd_data[%0d]", rd_addr), int'(rd_data), e.exp);
                    1: check("count", int'(count), e.exp);
                    2: check("in_ready", int'(in_ready), e.exp);
                    3: check("busy", int'(busy), e.exp);
                    4: check("full", int'(full), e.exp);
                    5: check("search_ok", int'(search_ok), e.exp);
                    default: check("accept_to_search_ok_cycles", lat_meas, e.exp);
                endcase
            end
        end
        if (busy) begin
            run_len++;
        end else if (run_len > 0) begin
            if (ins_q.size() == 0) begin
                check("unexpected_insertion", 1, 0);
            end else begin
                ins_t x;
                x = ins_q.pop_front();
                check("busy_cycles", run_len, x.busy_len);
                check("count_after_insert", int'(count), x.cnt);
            end
            run_len = 0;
        end
    end

    task automatic push(int k, int e);
        chk_t c;
        c.kind = k;
        c.exp  = e;
        sb_q.push_back(c);
    endtask

    task automatic strobe();
        chk_stb = 1'b1;
        @(posedge clk); #1;
        chk_stb = 1'b0;
    endtask

    task automatic status(int c, int r, int b, int f, int s);
        push(1, c); push(2, r); push(3, b); push(4, f); push(5, s);
        strobe();
    endtask

    task automatic dump(input int exp [16]);
        for (int i = 0; i < 16; i++) begin
            rd_addr = 4'(i);
            push(0, exp[i]);
            strobe();
        end
    endtask

    task automatic handshake(logic [7:0] d);
        int n;
        in_valid = 1'b1;
        in_data  = d;
        for (n = 0; n < 100; n++) begin
            @(negedge clk);
            if (in_ready) break;
        end
        if (n == 100) check("accept_timeout", 0, 1);
        last_acc = cyc;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic send_key(logic [7:0] d);
        int   k;
        int   idx;
        ins_t x;
        k = 0;
        idx = ref_q.size();
        for (int i = ref_q.size() - 1; i >= 0; i--) begin
            if (ref_q[i] > int'(d)) begin
                k++;
                idx = i;
            end
        end
        ref_q.insert(idx, int'(d));
        x.busy_len = k + 1;
        x.cnt      = ref_q.size();
        ins_q.push_back(x);
        handshake(d);
    endtask

    task automatic wait_idle();
        int n;
        for (n = 0; n < 100; n++) begin
            @(negedge clk);
            if (!busy) break;
        end
        if (n == 100) check("idle_timeout", 0, 1);
        @(posedge clk); #1;
    endtask

    task automatic do_clr();
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        ref_q.delete();
    endtask

    task automatic abort_test(bit use_rst);
        int   zeros [16];
        int   tbl [16];
        int   keys [16];
        ins_t x;
        zeros = '{default: 0};
        keys  = '{'h37, 'h05, 'hC2, 'h05, 'h9A, 'h00, 'hFF, 'h61,
                  'h2B, 'h84, 'h13, 'hEE, 'h70, 'h4D, 'hB5, 'h29};
        tbl   = '{'h00, 'h05, 'h05, 'h13, 'h29, 'h2B, 'h37, 'h4D,
                  'h61, 'h70, 'h84, 'h9A, 'hB5, 'hC2, 'hEE, 'hFF};
        do_clr();
        for (int i = 0; i < 10; i++) send_key(8'(8'h10 + i));
        // Key 0x00 must travel past all 10 entries; cut it off on SHIFT cycle 3.
        x.busy_len = 3;
        x.cnt      = 0;
        ins_q.push_back(x);
        handshake(8'h00);
        @(posedge clk); #1;
        @(posedge clk); #1;
        if (use_rst) rst = 1'b1; else clr = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        clr = 1'b0;
        ref_q.delete();
        status(0, 1, 0, 0, 0);
        if (use_rst) dump(zeros);
        for (int i = 0; i < 16; i++) send_key(8'(keys[i]));
        wait_idle();
        status(16, 0, 0, 1, 1);
        dump(tbl);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int tbl [16];
        int t0;
        int n;

        // Reset
        tbl = '{default: 0};
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        status(0, 1, 0, 0, 0);
        dump(tbl);

        // Ascending load: two cycles per key, 32 cycles to search_ok
        send_key(8'h00);
        t0 = last_acc;
        for (int i = 1; i < 16; i++) send_key(8'(i));
        for (n = 0; n < 100; n++) begin
            @(negedge clk);
            if (search_ok) break;
        end
        lat_meas = cyc - t0;
        @(posedge clk); #1;
        push(6, 32);
        status(16, 0, 0, 1, 1);
        for (int i = 0; i < 16; i++) tbl[i] = i;
        dump(tbl);

        // Descending load: j-th key shifts j entries
        do_clr();
        status(0, 1, 0, 0, 0);
        for (int j = 0; j < 16; j++) send_key(8'(8'hF0 - 8'h10 * j));
        wait_idle();
        for (int i = 0; i < 16; i++) tbl[i] = 16 * i;
        dump(tbl);

        // Duplicates and extremes
        do_clr();
        send_key(8'h80); send_key(8'hFF); send_key(8'h00);
        send_key(8'h80); send_key(8'hFF); send_key(8'h00);
        for (int i = 0; i < 10; i++) send_key(8'(8'h40 + i));
        wait_idle();
        tbl = '{'h00, 'h00, 'h40, 'h41, 'h42, 'h43, 'h44, 'h45,
                'h46, 'h47, 'h48, 'h49, 'h80, 'h80, 'hFF, 'hFF};
        dump(tbl);

        // Full back-pressure
        in_valid = 1'b1;
        in_data  = 8'h01;
        for (int i = 0; i < 5; i++) status(16, 0, 0, 1, 1);
        in_valid = 1'b0;
        dump(tbl);

        // Abort with clr, then with rst
        abort_test(1'b0);
        abort_test(1'b1);

        repeat (3) @(posedge clk);
        check("pending_insertions", ins_q.size(), 0);
        check("pending_checks", sb_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/sorted_array_loader.md
# sorted_array_loader

Ingress stage for the binary-search engine: accepts 8-bit keys one at a time over a valid/ready handshake and maintains them in a 16-entry array sorted ascending by online insertion sort. The binary-search datapath reads the array through a combinational read port and may start only when the loader reports `search_ok`. The loader guarantees the sorted-order precondition the search relies on, and its 4-bit index space matches the search result width.

## Interface
- `DEPTH`, 16, number of array entries; power of two.
- `AW`, 4, index width, log2(DEPTH).
- `DW`, 8, key width.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `clr`  in  1  synchronous clear: empties the array logically; contents are not zeroed.
- `in_valid`  in  1  key offered.
- `in_data`  in  DW  key value.
- `in_ready`  out  1  loader can accept a key this cycle.
- `rd_addr`  in  AW  read index from the search datapath.
- `rd_data`  out  DW  `mem[rd_addr]`, combinational.
- `count`  out  AW+1  number of valid entries, 0..DEPTH.
- `full`  out  1  `count == DEPTH`.
- `busy`  out  1  insertion in progress.
- `search_ok`  out  1  `full && !busy`.

## Operation
- Storage: `mem[0..DEPTH-1]` of DW bits. Entries `[0, count)` are sorted non-decreasing whenever `busy == 0`.
- FSM states:
  - IDLE: `in_ready = !full && !rst`. On the accept edge (`in_valid && in_ready`), latch `key <= in_data` and `pos <= count`, then go to SHIFT.
  - SHIFT: one compare per cycle.
    - If `pos > 0 && mem[pos-1] > key`: `mem[pos] <= mem[pos-1]`, `pos <= pos-1`, stay in SHIFT.
    - Otherwise: `mem[pos] <= key`, `count <= count+1`, go to IDLE.
- The compare is unsigned and strictly greater, so a new key lands after any existing equal keys.
- `in_ready = 0` in SHIFT. While full, `in_valid` is ignored and the array is unchanged.
- `busy = (state == SHIFT)`.
- `rst`: state IDLE, `count = 0`, all `mem` zeroed, `key`/`pos` zeroed. Has priority over `clr` and over the handshake.
- `clr`: state IDLE, `count = 0`, `mem` untouched. Aborts an insertion in progress; the partial shift is discarded logically. Has priority over an accept in the same cycle, so that key is dropped and `in_ready` is forced to 0 while `clr` is high.
- `rd_data` always reflects `mem[rd_addr]`. It is meaningful only for `rd_addr < count` with `busy == 0`. During SHIFT one entry is transiently duplicated.

## Timing
- Output values after reset: `in_ready = 1` (once `rst` is low), `count = 0`, `full = 0`, `busy = 0`, `search_ok = 0`, `rd_data = 0` for every address.
- For an insertion that moves k entries (0 ≤ k ≤ count):
  - `busy` is high for k+1 cycles after the accept edge.
  - `count` increments on the last SHIFT edge.
  - `in_ready` reasserts in the following cycle.
- Throughput is one key per k+2 cycles. The best case, ascending input, is one key per 2 cycles. The worst case is 17 cycles, for the 16th key when it is smaller than all others.
- `full` and `search_ok` rise in the same cycle that `count` becomes 16.
- `search_ok` falls on the cycle after a `clr` or `rst` edge.
- Position 0 boundary: when `pos` reaches 0, the key is written to `mem[0]` without reading `mem[-1]`.
- No wrap-around: `count` saturates at DEPTH by construction, because no accept is possible while full.

## Test plan
- Reset: hold `rst` for 2 cycles, then release. Required: `count = 0`, `in_ready = 1`, `busy = 0`, `full = 0`, `search_ok = 0`, and `rd_data = 0` for all 16 addresses.
- Ascending load 0x00..0x0F with `in_valid` held high. Required:
  - each accept is followed by exactly 1 busy cycle;
  - `full = 1` after the 16th insertion;
  - `rd_data[i] = i` for all i;
  - total time from first accept to `search_ok` is 32 cycles.
- Descending load 0xF0, 0xE0, …, 0x00. Required:
  - the j-th key (j = 0..15) keeps `busy` high for j+1 cycles;
  - final contents are `mem[i] = 0x10*i`.
- Duplicates and extremes: load 0x80, 0xFF, 0x00, 0x80, 0xFF, 0x00, then keys 0x40..0x49. Required: final sorted order 00,00,40,41,…,49,80,80,FF,FF, with unsigned compare holding at both 0x00 and 0xFF.
- Full back-pressure: after 16 keys, drive `in_valid = 1` with 0x01 for 5 cycles. Required: `in_ready = 0`, contents and `count` unchanged, `search_ok = 1` throughout.
- Abort:
  - Assert `clr` on the 3rd SHIFT cycle of an insertion into 10 entries. Required: next cycle `count = 0`, `busy = 0`, `in_ready = 1`; reloading 16 keys afterwards sorts correctly.
  - Repeat with `rst` instead of `clr`. Required: additionally `rd_data = 0` at all addresses.
